// File: rtl/addr_mode_sequencer.sv
// addr_mode_sequencer: resolves an operand effective address for the
// ZPG / ZPG_X / ZPG_Y / ABS / ABS_X / ABS_Y / IMM addressing modes by
// fetching operand bytes from the program stream, adding an index, and
// presenting the result with a valid/ready handshake.
//
// Optional feature macro: PAGE_CROSS_SKIP_EN
//   defined   -> indexed absolute modes visit FIXUP only when the low-byte
//                add carries (variable latency).
//   undefined -> indexed absolute modes always visit FIXUP (fixed latency);
//                page_cross is still reported.
module addr_mode_sequencer #(
   parameter int unsigned DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  rdy,
   input  logic                  start,
   input  logic [2:0]            mode,
   input  logic [DATA_W-1:0]     data_in,
   input  logic [DATA_W-1:0]     x_idx,
   input  logic [DATA_W-1:0]     y_idx,
   input  logic                  ea_ready,
   output logic                  pc_inc,
   output logic                  busy,
   output logic                  ea_valid,
   output logic [2*DATA_W-1:0]   ea,
   output logic                  page_cross,
   output logic                  mode_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_LO,
      S_FETCH_HI,
      S_INDEX,
      S_FIXUP,
      S_DONE
   } state_t;

   typedef enum logic [2:0] {
      M_ZPG   = 3'd0,
      M_ZPG_X = 3'd1,
      M_ZPG_Y = 3'd2,
      M_ABS   = 3'd3,
      M_ABS_X = 3'd4,
      M_ABS_Y = 3'd5,
      M_IMM   = 3'd6,
      M_RSVD  = 3'd7
   } mode_t;

   state_t              state_q, state_n;
   mode_t               mode_q, mode_n;
   logic [DATA_W-1:0]   lo_q, lo_n;
   logic [DATA_W-1:0]   hi_q, hi_n;
   logic                cross_q, cross_n;
   logic                err_q, err_n;

   logic                use_x;
   logic                zero_page;
   logic [DATA_W-1:0]   idx;
   logic [DATA_W:0]     sum;

   // Index operand selection and the carry-producing low-byte add.
   always_comb begin
      use_x     = (mode_q == M_ZPG_X) || (mode_q == M_ABS_X);
      zero_page = (mode_q == M_ZPG_X) || (mode_q == M_ZPG_Y);
      idx       = use_x ? x_idx : y_idx;
      sum       = {1'b0, lo_q} + {1'b0, idx};
   end

   // State and datapath registers; asynchronous reset clears everything.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= S_IDLE;
         mode_q  <= M_ZPG;
         lo_q    <= '0;
         hi_q    <= '0;
         cross_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         mode_q  <= mode_n;
         lo_q    <= lo_n;
         hi_q    <= hi_n;
         cross_q <= cross_n;
         err_q   <= err_n;
      end
   end

   // Next-state, datapath update and pc_inc; everything holds while rdy is low.
   always_comb begin
      state_n = state_q;
      mode_n  = mode_q;
      lo_n    = lo_q;
      hi_n    = hi_q;
      cross_n = cross_q;
      err_n   = err_q;
      pc_inc  = 1'b0;

      if (rdy) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_n  = mode_t'(mode);
                  state_n = S_FETCH_LO;
               end
            end

            S_FETCH_LO: begin
               if (mode_q == M_RSVD) begin
                  // Reserved mode: consume nothing, report a zero address.
                  lo_n    = '0;
                  hi_n    = '0;
                  err_n   = 1'b1;
                  state_n = S_DONE;
               end else begin
                  pc_inc = 1'b1;
                  lo_n   = data_in;
                  hi_n   = '0;
                  case (mode_q)
                     M_ABS, M_ABS_X, M_ABS_Y: state_n = S_FETCH_HI;
                     M_ZPG_X, M_ZPG_Y:        state_n = S_INDEX;
                     default:                 state_n = S_DONE;
                  endcase
               end
            end

            S_FETCH_HI: begin
               pc_inc  = 1'b1;
               hi_n    = data_in;
               state_n = (mode_q == M_ABS) ? S_DONE : S_INDEX;
            end

            S_INDEX: begin
               lo_n = sum[DATA_W-1:0];
               if (zero_page) begin
                  // Zero-page indexing wraps within page 0; carry discarded.
                  hi_n    = '0;
                  state_n = S_DONE;
               end else begin
                  cross_n = sum[DATA_W];
`ifdef PAGE_CROSS_SKIP_EN
                  state_n = sum[DATA_W] ? S_FIXUP : S_DONE;
`else
                  state_n = S_FIXUP;
`endif
               end
            end

            S_FIXUP: begin
               // Carry into the high byte; the top page wraps to page 0.
               hi_n    = hi_q + DATA_W'(cross_q);
               state_n = S_DONE;
            end

            S_DONE: begin
               if (ea_ready) begin
                  cross_n = 1'b0;
                  err_n   = 1'b0;
                  if (start) begin
                     mode_n  = mode_t'(mode);
                     state_n = S_FETCH_LO;
                  end else begin
                     state_n = S_IDLE;
                  end
               end
            end

            default: state_n = S_IDLE;
         endcase
      end
   end

   // Status outputs decoded directly from registered state.
   always_comb begin
      busy       = (state_q != S_IDLE);
      ea_valid   = (state_q == S_DONE);
      ea         = {hi_q, lo_q};
      page_cross = cross_q;
      mode_err   = err_q;
   end

endmodule
